// File: rtl/blinker_bank_if.sv
// Configuration write port for blinker_bank: single-cycle strobe with channel, field select and data.
interface blinker_bank_if;
  logic        cfg_we;
  logic [3:0]  cfg_ch;
  logic [2:0]  cfg_sel;
  logic [15:0] cfg_data;

  modport master (output cfg_we, cfg_ch, cfg_sel, cfg_data);
  modport slave  (input  cfg_we, cfg_ch, cfg_sel, cfg_data);
endinterface

// File: rtl/blinker_bank.sv
// NCH-channel blinker/PWM indicator driver sharing one free-running counter.
// Optional burst-count feature enabled by defining BLINKER_BANK_BURST_EN.
module blinker_bank #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  blinker_bank_if.slave  cfg,
  output logic [NCH-1:0] blink_out,
  output logic           tick
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  localparam logic [4:0] NCH_L     = 5'(NCH);
  localparam logic [4:0] CW_L      = 5'(CW);
  localparam logic [3:0] TOP_BIT   = 4'(CW - 1);
  localparam logic [3:0] SHIFT_RST = 4'd9;
`ifdef BLINKER_BANK_BURST_EN
  localparam logic [2:0] SEL_LIM   = 3'd5;
`else
  localparam logic [2:0] SEL_LIM   = 3'd4;
`endif

  logic [CW-1:0]  cnt_q;
  mode_e          mode_q   [NCH];
  logic [CW-1:0]  offset_q [NCH];
  logic [7:0]     duty_q   [NCH];
  logic [3:0]     shift_q  [NCH];

  logic           wr_ok;
  logic [NCH-1:0] wr_mode, wr_offset, wr_duty, wr_shift;
  logic [NCH-1:0] out_d;
  logic [CW-1:0]  phase;
  logic [3:0]     bidx;
  logic           unused_cfg;

`ifdef BLINKER_BANK_BURST_EN
  logic [7:0]     burst_q [NCH];
  logic [NCH-1:0] wr_burst;
  logic [NCH-1:0] burst_dec;
`endif

  assign unused_cfg = ^cfg.cfg_data;

  // Write decode: out-of-range channel or field leaves every register untouched.
  always_comb begin
    wr_ok     = cfg.cfg_we && ({1'b0, cfg.cfg_ch} < NCH_L) && (cfg.cfg_sel < SEL_LIM);
    wr_mode   = '0;
    wr_offset = '0;
    wr_duty   = '0;
    wr_shift  = '0;
`ifdef BLINKER_BANK_BURST_EN
    wr_burst  = '0;
`endif
    for (int unsigned i = 0; i < NCH; i++) begin
      if (wr_ok && (cfg.cfg_ch == 4'(i))) begin
        wr_mode[i]   = (cfg.cfg_sel == 3'd0);
        wr_offset[i] = (cfg.cfg_sel == 3'd1);
        wr_duty[i]   = (cfg.cfg_sel == 3'd2);
        wr_shift[i]  = (cfg.cfg_sel == 3'd3);
`ifdef BLINKER_BANK_BURST_EN
        wr_burst[i]  = (cfg.cfg_sel == 3'd4);
`endif
      end
    end
  end

  always_comb begin
    out_d = '0;
    phase = '0;
    bidx  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      phase = cnt_q + offset_q[i];
      bidx  = ({1'b0, shift_q[i]} >= CW_L) ? TOP_BIT : shift_q[i];
      unique case (mode_q[i])
        MODE_OFF:   out_d[i] = 1'b0;
        MODE_ON:    out_d[i] = 1'b1;
        MODE_BLINK: out_d[i] = phase[bidx];
        MODE_PWM:   out_d[i] = (phase[7:0] < duty_q[i]);
        default:    out_d[i] = 1'b0;
      endcase
    end
  end

`ifdef BLINKER_BANK_BURST_EN
  // A burst count is consumed on each falling edge of the registered output.
  always_comb begin
    burst_dec = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      burst_dec[i] = blink_out[i] && !out_d[i] && (burst_q[i] != '0) &&
                     ((mode_q[i] == MODE_BLINK) || (mode_q[i] == MODE_PWM));
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      tick      <= 1'b0;
      blink_out <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        mode_q[i]   <= MODE_OFF;
        offset_q[i] <= '0;
        duty_q[i]   <= '0;
        shift_q[i]  <= SHIFT_RST;
`ifdef BLINKER_BANK_BURST_EN
        burst_q[i]  <= '0;
`endif
      end
    end else begin
      if (en) begin
        cnt_q <= cnt_q + CW'(1);
      end
      tick      <= en && (cnt_q == '1);
      blink_out <= out_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (wr_offset[i]) offset_q[i] <= cfg.cfg_data[CW-1:0];
        if (wr_duty[i])   duty_q[i]   <= cfg.cfg_data[7:0];
        if (wr_shift[i])  shift_q[i]  <= cfg.cfg_data[3:0];
`ifdef BLINKER_BANK_BURST_EN
        // Explicit writes take priority over the decrement and auto-OFF.
        if (wr_mode[i]) begin
          mode_q[i] <= mode_e'(cfg.cfg_data[1:0]);
        end else if (burst_dec[i] && (burst_q[i] == 8'd1)) begin
          mode_q[i] <= MODE_OFF;
        end
        if (wr_burst[i]) begin
          burst_q[i] <= cfg.cfg_data[7:0];
        end else if (burst_dec[i]) begin
          burst_q[i] <= burst_q[i] - 8'd1;
        end
`else
        if (wr_mode[i]) mode_q[i] <= mode_e'(cfg.cfg_data[1:0]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_blinker_bank.sv
// Self-checking bench for blinker_bank: CW=16 and CW=8 instances against a behavioural model.
module tb_blinker_bank;
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [3:0] b16, b8;
  logic       t16, t8;

  blinker_bank_if bus ();

  blinker_bank #(.NCH(4), .CW(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg(bus.slave), .blink_out(b16), .tick(t16)
  );
  blinker_bank #(.NCH(4), .CW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg(bus.slave), .blink_out(b8), .tick(t8)
  );

  always #5 clk = ~clk;

`ifdef BLINKER_BANK_BURST_EN
  localparam int SEL_N = 5;
  localparam bit BURST = 1'b1;
`else
  localparam int SEL_N = 4;
  localparam bit BURST = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: index 0 is the CW=16 instance, index 1 the CW=8 instance.
  int       m_cnt   [2];
  int       m_mode  [2][4];
  int       m_off   [2][4];
  int       m_duty  [2][4];
  int       m_sh    [2][4];
  int       m_burst [2][4];
  bit [3:0] m_out   [2];
  bit       m_tick  [2];

  function automatic int cw_of(input int k);
    return (k == 0) ? 16 : 8;
  endfunction

  function automatic bit level(input int k, input int c);
    int cw, p, b;
    cw = cw_of(k);
    p  = (m_cnt[k] + m_off[k][c]) % (1 << cw);
    b  = (m_sh[k][c] < cw) ? m_sh[k][c] : cw - 1;
    case (m_mode[k][c])
      1:       return 1'b1;
      2:       return ((p >> b) & 1) != 0;
      3:       return (p % 256) < m_duty[k][c];
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [3:0] next_out(input int k);
    bit [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = level(k, c);
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k]  <= 0;
        m_out[k]  <= '0;
        m_tick[k] <= 1'b0;
        for (int c = 0; c < 4; c++) begin
          m_mode[k][c]  <= 0;
          m_off[k][c]   <= 0;
          m_duty[k][c]  <= 0;
          m_sh[k][c]    <= 9;
          m_burst[k][c] <= 0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_out[k]  <= next_out(k);
        m_tick[k] <= en && (m_cnt[k] == (1 << cw_of(k)) - 1);
        if (en) m_cnt[k] <= (m_cnt[k] + 1) % (1 << cw_of(k));
        for (int c = 0; c < 4; c++) begin
          if (BURST && m_out[k][c] && !level(k, c) && m_burst[k][c] != 0 && m_mode[k][c] >= 2) begin
            m_burst[k][c] <= m_burst[k][c] - 1;
            if (m_burst[k][c] == 1) m_mode[k][c] <= 0;
          end
        end
        // Later assignments override the burst update above.
        if (bus.cfg_we && bus.cfg_ch < 4 && int'(bus.cfg_sel) < SEL_N) begin
          case (bus.cfg_sel)
            3'd0: m_mode[k][bus.cfg_ch[1:0]]  <= int'(bus.cfg_data) % 4;
            3'd1: m_off[k][bus.cfg_ch[1:0]]   <= int'(bus.cfg_data) % (1 << cw_of(k));
            3'd2: m_duty[k][bus.cfg_ch[1:0]]  <= int'(bus.cfg_data) % 256;
            3'd3: m_sh[k][bus.cfg_ch[1:0]]    <= int'(bus.cfg_data) % 16;
            3'd4: m_burst[k][bus.cfg_ch[1:0]] <= int'(bus.cfg_data) % 256;
            default: ;
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("blink_out_cw16", int'(b16), int'(m_out[0]));
    chk("tick_cw16",      int'(t16), int'(m_tick[0]));
    chk("blink_out_cw8",  int'(b8),  int'(m_out[1]));
    chk("tick_cw8",       int'(t8),  int'(m_tick[1]));
  end

  // Called right after a falling edge; the write lands on the following rising edge.
  task automatic wr(input int ch, input int sel, input int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = 4'(ch);
    bus.cfg_sel  = 3'(sel);
    bus.cfg_data = 16'(data);
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  initial begin
    int n, hi0, hi1, tk8, tk16, last0, rises, his, prev, guard;

    // Reset with a write pending on the bus.
    bus.cfg_we = 1'b1; bus.cfg_ch = 4'd0; bus.cfg_sel = 3'd0; bus.cfg_data = 16'd1;
    repeat (3) @(negedge clk);
    chk("reset_blink_out", int'(b16), 0);
    chk("reset_tick", int'(t16), 0);
    bus.cfg_we = 1'b0;
    rst_n = 1'b1;
    en = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b0;
    chk("after5_blink_out", int'(b16 | b8), 0);
    chk("after5_model_cnt", m_cnt[0], 5);

    // Asynchronous reset mid-operation with a channel driving high.
    wr(0, 0, 1);
    @(negedge clk);
    chk("on_before_reset", int'(b16[0]), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_clears", int'(b16), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ch0 BLINK offset 0x100 shift 9, ch1 PWM duty 64.
    wr(0, 3, 9);
    wr(0, 1, 'h100);
    wr(0, 0, 2);
    wr(1, 2, 64);
    wr(1, 0, 3);
    en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b16[0] && n < 2000);
    chk("blink_first_rise_edge", n, 257);

    hi0 = 0; hi1 = 0; tk8 = 0; tk16 = 0; last0 = 0;
    for (int i = 0; i < 1024; i++) begin
      if (i > 0) @(negedge clk);
      hi0  += int'(b16[0]);
      hi1  += int'(b16[1]);
      tk8  += int'(t8);
      tk16 += int'(t16);
      last0 = int'(b16[0]);
    end
    @(negedge clk);
    chk("blink_high_per_period", hi0, 512);
    chk("blink_last_low", last0, 0);
    chk("blink_period_1024", int'(b16[0]), 1);
    chk("pwm64_high_in_1024", hi1, 256);
    chk("tick_cw8_in_1024", tk8, 4);
    chk("tick_cw16_no_wrap", tk16, 0);

    // Hold the CW=8 counter across its wrap point.
    guard = 0;
    while (m_cnt[1] != 250 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_cnt8_250", m_cnt[1], 250);
    en = 1'b0;
    tk8 = 0;
    repeat (300) begin
      @(negedge clk);
      tk8 += int'(t8);
    end
    chk("no_tick_en0", tk8, 0);
    chk("cnt8_hold", m_cnt[1], 250);
    en = 1'b1;
    tk8 = 0;
    repeat (10) begin
      @(negedge clk);
      tk8 += int'(t8);
    end
    chk("tick_after_resume", tk8, 1);

    // Invalid writes change nothing.
    for (int c = 0; c < 4; c++) wr(c, 0, 0);
    wr(4, 0, 1);
    wr(0, 7, 1);
    repeat (2) @(negedge clk);
    chk("invalid_ch_ignored", int'(b16), 0);
    chk("invalid_sel_ignored", int'(b8), 0);

    // PWM duty 0 never high; ON one cycle after its write.
    wr(1, 2, 0);
    wr(1, 0, 3);
    hi1 = 0;
    repeat (256) begin
      @(negedge clk);
      hi1 += int'(b16[1]);
    end
    chk("pwm_duty0_never_high", hi1, 0);
    wr(1, 0, 1);
    chk("on_latency_edge0", int'(b16[1]), 0);
    @(negedge clk);
    chk("on_latency_edge1", int'(b16[1]), 1);
    wr(1, 0, 0);

    // ch2 BLINK shift 2 burst 3, phase aligned so p=0 when counting restarts.
    en = 1'b0;
    wr(2, 3, 2);
    wr(2, 4, 3);
    wr(2, 1, (65536 - m_cnt[0]) % 65536);
    wr(2, 0, 2);
    en = 1'b1;
    rises = 0; his = 0; prev = 0;
    repeat (120) begin
      @(negedge clk);
      his += int'(b16[2]);
      if (b16[2] && prev == 0) rises++;
      prev = int'(b16[2]);
    end
`ifdef BLINKER_BANK_BURST_EN
    chk("burst_pulse_count", rises, 3);
    chk("burst_high_cycles", his, 12);
`else
    chk("blink_pulse_count", rises, 15);
    chk("blink_high_cycles", his, 60);
`endif

    // Randomised traffic, including invalid channels/fields and one reset.
    for (int i = 0; i < 3000; i++) begin
      en           = ($urandom_range(0, 3) != 0);
      bus.cfg_we   = ($urandom_range(0, 3) == 0);
      bus.cfg_ch   = 4'($urandom_range(0, 5));
      bus.cfg_sel  = 3'($urandom_range(0, 7));
      bus.cfg_data = 16'($urandom);
      if (i == 1500) rst_n = 1'b0;
      if (i == 1503) rst_n = 1'b1;
      @(negedge clk);
    end
    bus.cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blinker_bank.md
# blinker_bank

Multi-channel, register-configured LED/indicator driver that generalises the single-output fixed-bit blinker into NCH independent channels sharing one free-running counter. Each channel has its own phase offset, selectable blink bit, PWM duty and mode, all written through a simple write port. It sits between the top-level control logic and the dedicated outputs and replaces per-output blinker instances.

## Interface
- NCH, 4: number of channels (1..16)
- CW, 16: shared counter width (8..16)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  counter advance enable
- cfg_we  in  1  configuration write strobe, single-cycle
- cfg_ch  in  4  target channel index
- cfg_sel  in  3  field select: 0 mode, 1 offset, 2 duty, 3 shift, 4 burst
- cfg_data  in  16  write data, low bits used per field
- blink_out  out  NCH  registered channel outputs
- tick  out  1  one-cycle pulse on counter wrap

## Operation
- Counter cnt[CW-1:0]: +1 per cycle when en=1, holds when en=0; wraps 2^CW-1 -> 0.
- Per-channel fields: mode[1:0], offset[CW-1:0], duty[7:0], shift[3:0], burst[7:0].
- Phase value p = (cnt + offset) mod 2^CW, per channel.
- Modes: 0 OFF -> 0; 1 ON -> 1; 2 BLINK -> p[shift]; 3 PWM -> (p[7:0] < duty).
- shift >= CW: bit index taken as CW-1.
- PWM duty 0 -> constant 0; duty 255 -> high 255 of every 256 phase counts.
- Write: on edge with cfg_we=1, field cfg_sel of channel cfg_ch loads cfg_data (truncated to field width).
- cfg_ch >= NCH or cfg_sel >= 5 (>= 4 without burst feature): write ignored, no state change.
- en and cfg_we in same cycle: both take effect.
- tick=1 for exactly the cycle after cnt transitions 2^CW-1 -> 0; no tick while en=0.

## Timing
- Reset (async assert, sync-safe release): cnt=0, all mode=OFF, offset=0, duty=0, shift=9, burst=0, blink_out=0, tick=0.
- blink_out at edge t+1 = f(cnt, fields) as held after edge t: one-cycle latency from counter/config to output.
- Config written at edge t is reflected on blink_out at edge t+1.
- Reset mid-operation: all state returns to reset values immediately; first count after release is cnt=1 at first en=1 edge.

## Configuration
- BLINKER_BANK_BURST_EN defined: burst field exists; in BLINK or PWM with burst != 0, each 1->0 transition of that channel's blink_out decrements burst; the edge where burst goes 1 -> 0 also writes mode=OFF, so blink_out is 0 from the next edge. burst=0 means unlimited. A write to burst or mode in the same cycle as a decrement wins over the decrement/auto-OFF.
- Not defined: no burst storage or logic; cfg_sel=4 writes ignored; channels run until mode is rewritten.

## Test plan
- Reset with writes pending -> blink_out=0, tick=0, cnt=0; after release, en=1 for 5 cycles -> cnt=5, all outputs 0.
- Ch0 mode=BLINK, shift=9, offset=0x0100, en=1 -> blink_out[0] first rises at edge following cnt=0x0100 (p=0x0200), period 1024 cycles, 50 % duty.
- Ch1 mode=PWM, duty=64 -> 64 high cycles then 192 low per 256 cycles; duty=0 -> never high; ch1 mode=ON -> constant 1 next cycle.
- CW=8, en=1 from reset -> tick high one cycle after cnt 255->0, every 256 cycles; en=0 across wrap point -> no tick, cnt holds.
- Write cfg_ch=NCH (e.g. 4), cfg_sel=0, data=1 -> no channel changes; cfg_sel=7 -> ignored.
- With BLINKER_BANK_BURST_EN, ch2 BLINK shift=2 burst=3 -> exactly 3 high pulses of 4 cycles, then mode reads OFF and output stays 0; without macro same writes -> continuous blinking.
